ofifo_psum: RTL and testbench

- Output collection FIFO directly downstream of the array of column MAC units.
- Each column drives one bw_psum-bit partial sum with its own write strobe. Columns finish at staggered cycles because of the diagonal skew.
- The block buffers each column in an independent lane and presents a complete, row-aligned vector of all col results to the consumer (softmax/normalisation or SRAM writeback) through a valid/read handshake.
- It also flags overflow and underflow as sticky errors for the controller.

---
 rtl/fifo_lane.sv | 56 +++++
 rtl/ofifo_psum.sv | 75 +++++++
 tb/tb_ofifo_psum.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_lane.sv
// Single-lane circular buffer with first-word fall-through output.
// Accept decisions are made by the parent; wr and pop here are already qualified.
module fifo_lane #(
    parameter int unsigned BW        = 11,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned DEPTH_LOG = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr,
    input  logic          pop,
    input  logic [BW-1:0] in,
    output logic [BW-1:0] out,
    output logic          empty,
    output logic          full
);

    localparam logic [DEPTH_LOG:0] PTR_ONE = 1;

    logic [BW-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG:0] rd_ptr_q, rd_ptr_d;

    // Next pointer values; the extra MSB is the wrap bit
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr)  wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    // Pointer registers, cleared by reset to discard buffered data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is never reset; writes during reset are suppressed
    always_ff @(posedge clk) begin
        if (wr && !reset) mem_q[wr_ptr_q[DEPTH_LOG-1:0]] <= in;
    end

    // Status and fall-through head
    always_comb begin
        empty = (rd_ptr_q == wr_ptr_q);
        full  = (rd_ptr_q[DEPTH_LOG-1:0] == wr_ptr_q[DEPTH_LOG-1:0]) &&
                (rd_ptr_q[DEPTH_LOG] != wr_ptr_q[DEPTH_LOG]);
        out   = mem_q[rd_ptr_q[DEPTH_LOG-1:0]];
    end

endmodule

// File: rtl/ofifo_psum.sv
// Output collection FIFO for the MAC column array: one lane per column,
// popped together so the consumer always sees a row-aligned vector.
module ofifo_psum #(
    parameter int unsigned col       = 8,
    parameter int unsigned bw_psum   = 11,
    parameter int unsigned depth     = 16,
    parameter int unsigned depth_log = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [col*bw_psum-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [col*bw_psum-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   o_overflow,
    output logic                   o_underflow
);

    logic [col-1:0] empty;
    logic [col-1:0] full;
    logic [col-1:0] wr_acc;
    logic           pop;
    logic           overflow_q, overflow_d;
    logic           underflow_q, underflow_d;

    // Accept logic: a full lane still takes a write when the row pops this cycle
    always_comb begin
        o_valid = ~|empty;
        o_full  = |full;
        o_ready = ~o_full;
        pop     = rd & o_valid;
        wr_acc  = wr & (~full | {col{pop}});
    end

    for (genvar g = 0; g < col; g++) begin : g_lane
        fifo_lane #(
            .BW        (bw_psum),
            .DEPTH     (depth),
            .DEPTH_LOG (depth_log)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .wr    (wr_acc[g]),
            .pop   (pop),
            .in    (in[g*bw_psum +: bw_psum]),
            .out   (out[g*bw_psum +: bw_psum]),
            .empty (empty[g]),
            .full  (full[g])
        );
    end

    // Sticky error flag next state
    always_comb begin
        overflow_d  = overflow_q  | (|(wr & ~wr_acc));
        underflow_d = underflow_q | (rd & ~o_valid);
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign o_overflow  = overflow_q;
    assign o_underflow = underflow_q;

endmodule

// File: tb/tb_ofifo_psum.sv
// Directed self-checking bench for ofifo_psum.
module tb_ofifo_psum;

    localparam int COL = 8;
    localparam int BW  = 11;

    logic                clk = 1'b0;
    logic                reset;
    logic [COL*BW-1:0]   in_v;
    logic [COL-1:0]      wr;
    logic                rd;
    logic [COL*BW-1:0]   out_v;
    logic                o_valid, o_full, o_ready, o_overflow, o_underflow;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    ofifo_psum #(.col(COL), .bw_psum(BW), .depth(16), .depth_log(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .in          (in_v),
        .wr          (wr),
        .rd          (rd),
        .out         (out_v),
        .o_valid     (o_valid),
        .o_full      (o_full),
        .o_ready     (o_ready),
        .o_overflow  (o_overflow),
        .o_underflow (o_underflow)
    );

    // Advance one rising edge, then settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill16();
        for (int k = 0; k < 16; k++) begin
            wr = '1;
            for (int i = 0; i < COL; i++) in_v[i*BW +: BW] = 11'(k*8 + i);
            step();
        end
        wr = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; wr = '0; rd = 1'b0; in_v = '0;
        step(); step();
        reset = 1'b0;
        step();
        vectors++;
        if ({o_valid, o_full, o_ready, o_overflow, o_underflow} !== 5'b00100) begin
            errors++;
            $display("FAIL reset_status got %b want 00100", {o_valid, o_full, o_ready, o_overflow, o_underflow});
        end
    endtask

    task automatic test_staggered();
        for (int i = 0; i < COL; i++) begin
            wr = '0; wr[i] = 1'b1;
            in_v[i*BW +: BW] = 11'(100 + i);
            step();
            vectors++;
            if (o_valid !== (i == COL-1)) begin
                errors++;
                $display("FAIL stagger_valid lane%0d got %b want %b", i, o_valid, (i == COL-1));
            end
        end
        wr = '0;
        for (int i = 0; i < COL; i++) begin
            vectors++;
            if (out_v[i*BW +: BW] !== 11'(100 + i)) begin
                errors++;
                $display("FAIL stagger_out lane%0d got %0d want %0d", i, out_v[i*BW +: BW], 100 + i);
            end
        end
        rd = 1'b1; step(); rd = 1'b0;
        vectors++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL stagger_pop_valid got %b want 0", o_valid);
        end
    endtask

    task automatic test_fill_drain();
        fill16();
        vectors++;
        if ({o_full, o_ready, o_valid} !== 3'b101) begin
            errors++;
            $display("FAIL fill_status got %b want 101", {o_full, o_ready, o_valid});
        end
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < COL; i++) begin
                vectors++;
                if (out_v[i*BW +: BW] !== 11'(k*8 + i)) begin
                    errors++;
                    $display("FAIL drain_out k%0d lane%0d got %0d want %0d", k, i, out_v[i*BW +: BW], k*8 + i);
                end
            end
            rd = 1'b1; step(); rd = 1'b0;
        end
        vectors++;
        if ({o_valid, o_overflow} !== 2'b00) begin
            errors++;
            $display("FAIL drain_end got valid/ovf %b want 00", {o_valid, o_overflow});
        end
    endtask

    task automatic test_full_wr_pop();
        fill16();
        wr = '1; rd = 1'b1;
        for (int i = 0; i < COL; i++) in_v[i*BW +: BW] = 11'h3FF;
        step();
        wr = '0; rd = 1'b0;
        vectors++;
        if ({o_full, o_overflow} !== 2'b10) begin
            errors++;
            $display("FAIL wrpop_status got full/ovf %b want 10", {o_full, o_overflow});
        end
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < COL; i++) begin
                vectors++;
                if (out_v[i*BW +: BW] !== ((k == 15) ? 11'h3FF : 11'((k+1)*8 + i))) begin
                    errors++;
                    $display("FAIL wrpop_out k%0d lane%0d got %0h want %0h", k, i, out_v[i*BW +: BW],
                             (k == 15) ? 11'h3FF : 11'((k+1)*8 + i));
                end
            end
            rd = 1'b1; step(); rd = 1'b0;
        end
        vectors++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrpop_empty got %b want 0", o_valid);
        end
    endtask

    task automatic test_overflow();
        fill16();
        wr = 8'b0000_1000;
        in_v[3*BW +: BW] = 11'h555;
        step();
        wr = '0;
        vectors++;
        if (o_overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set got %b want 1", o_overflow);
        end
        step(); step();
        vectors++;
        if (o_overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky got %b want 1", o_overflow);
        end
        for (int k = 0; k < 16; k++) begin
            vectors++;
            if (out_v[3*BW +: BW] !== 11'(k*8 + 3)) begin
                errors++;
                $display("FAIL overflow_lane3 k%0d got %0h want %0h", k, out_v[3*BW +: BW], k*8 + 3);
            end
            rd = 1'b1; step(); rd = 1'b0;
        end
        vectors++;
        if ({o_valid, o_overflow} !== 2'b01) begin
            errors++;
            $display("FAIL overflow_end got valid/ovf %b want 01", {o_valid, o_overflow});
        end
    endtask

    task automatic test_underflow();
        rd = 1'b1; step(); rd = 1'b0;
        vectors++;
        if ({o_underflow, o_valid} !== 2'b10) begin
            errors++;
            $display("FAIL underflow_set got unf/valid %b want 10", {o_underflow, o_valid});
        end
        wr = '1;
        for (int i = 0; i < COL; i++) in_v[i*BW +: BW] = 11'(40 + i);
        step();
        wr = '0;
        vectors++;
        if (o_valid !== 1'b1) begin
            errors++;
            $display("FAIL underflow_rewrite_valid got %b want 1", o_valid);
        end
        for (int i = 0; i < COL; i++) begin
            vectors++;
            if (out_v[i*BW +: BW] !== 11'(40 + i)) begin
                errors++;
                $display("FAIL underflow_out lane%0d got %0d want %0d", i, out_v[i*BW +: BW], 40 + i);
            end
        end
        rd = 1'b1; step(); rd = 1'b0;
        vectors++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL underflow_pop got valid %b want 0", o_valid);
        end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 8; k++) begin
            wr = '1;
            for (int i = 0; i < COL; i++) in_v[i*BW +: BW] = 11'(k + 1);
            step();
        end
        wr = '0;
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if ({o_valid, o_full, o_ready, o_overflow, o_underflow} !== 5'b00100) begin
            errors++;
            $display("FAIL async_reset got %b want 00100", {o_valid, o_full, o_ready, o_overflow, o_underflow});
        end
        wr = '1;
        for (int i = 0; i < COL; i++) in_v[i*BW +: BW] = 11'd7;
        step();
        wr = '0;
        reset = 1'b0;
        vectors++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_cycle_write got valid %b want 0", o_valid);
        end
        wr = '1;
        for (int i = 0; i < COL; i++) in_v[i*BW +: BW] = 11'd5;
        step();
        wr = '0;
        for (int i = 0; i < COL; i++) begin
            vectors++;
            if (out_v[i*BW +: BW] !== 11'd5) begin
                errors++;
                $display("FAIL post_reset_out lane%0d got %0d want 5", i, out_v[i*BW +: BW]);
            end
        end
        rd = 1'b1; step(); rd = 1'b0;
        vectors++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_single got valid %b want 0", o_valid);
        end
    endtask

    initial begin
        test_reset();
        test_staggered();
        test_fill_drain();
        test_full_wr_pop();
        test_overflow();
        test_underflow();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
